// File: rtl/dma_arbiter_if.sv
// rtl/dma_arbiter_if.sv - requester/DMA bundle for dma_arbiter; carries grant_count when DMA_ARB_STATS_EN is defined
interface dma_arbiter_if #(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16
);
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ-1:0]        req_rw;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]        grant;
  logic [NUM_REQ-1:0]        preempted;
  logic                      dma_enable;
  logic                      dma_rw;
  logic [ADDR_W-1:0]         dma_addr;
  logic [DATA_W-1:0]         dma_wdata;
  logic                      busy;

`ifdef DMA_ARB_STATS_EN
  logic [NUM_REQ*16-1:0]     grant_count;

  modport master (
    input  req, req_rw, req_addr, req_wdata,
    output grant, preempted, dma_enable, dma_rw, dma_addr, dma_wdata, busy, grant_count
  );
  modport slave (
    output req, req_rw, req_addr, req_wdata,
    input  grant, preempted, dma_enable, dma_rw, dma_addr, dma_wdata, busy, grant_count
  );
`else
  modport master (
    input  req, req_rw, req_addr, req_wdata,
    output grant, preempted, dma_enable, dma_rw, dma_addr, dma_wdata, busy
  );
  modport slave (
    output req, req_rw, req_addr, req_wdata,
    input  grant, preempted, dma_enable, dma_rw, dma_addr, dma_wdata, busy
  );
`endif
endinterface

// File: rtl/dma_arbiter.sv
// rtl/dma_arbiter.sv - round-robin DMA port arbiter with hold limit and one-cycle turnaround gap
// Optional per-requester grant counters are enabled by defining DMA_ARB_STATS_EN.
module dma_arbiter #(
  parameter int NUM_REQ  = 3,
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 16,
  parameter int MAX_HOLD = 64
) (
  input  logic          clk,
  input  logic          reset,
  dma_arbiter_if.master bus
);
  localparam int IW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int HW        = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
  localparam int HOLD_LAST = (MAX_HOLD > 0) ? MAX_HOLD - 1 : 0;
  localparam logic [HW-1:0] HOLD_LAST_C = HW'(HOLD_LAST);
  localparam bit   PREEMPT_EN = (MAX_HOLD != 0);

  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] GRANT = 2'b01;
  localparam logic [1:0] GAP   = 2'b10;

  logic [1:0]         state;
  logic [NUM_REQ-1:0] grantQ;
  logic [NUM_REQ-1:0] preemptQ;
  logic [HW-1:0]      holdCnt;
  logic [IW-1:0]      lastIdx;

  logic               winValid;
  logic [IW-1:0]      winIdx;
  logic [NUM_REQ-1:0] winOneHot;
  logic               ownerReq;
  logic               othersReq;

  // Search begins just after the previous winner so every requester gets a turn.
  always_comb begin
    int idx;
    idx       = 0;
    winValid  = 1'b0;
    winIdx    = '0;
    winOneHot = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(lastIdx) + k) % NUM_REQ;
      if (!winValid && bus.req[idx]) begin
        winValid       = 1'b1;
        winIdx         = IW'(idx);
        winOneHot[idx] = 1'b1;
      end
    end
  end

  assign ownerReq  = |(bus.req & grantQ);
  assign othersReq = |(bus.req & ~grantQ);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      grantQ   <= '0;
      preemptQ <= '0;
      holdCnt  <= '0;
      lastIdx  <= IW'(NUM_REQ - 1);
    end else begin
      preemptQ <= '0;
      case (state)
        IDLE, GAP: begin
          if (winValid) begin
            grantQ  <= winOneHot;
            lastIdx <= winIdx;
            holdCnt <= '0;
            state   <= GRANT;
          end else begin
            grantQ <= '0;
            state  <= IDLE;
          end
        end
        GRANT: begin
          // A voluntary release wins over a timeout, so no preempt pulse then.
          if (!ownerReq) begin
            grantQ <= '0;
            state  <= GAP;
          end else if (PREEMPT_EN && holdCnt == HOLD_LAST_C && othersReq) begin
            grantQ   <= '0;
            preemptQ <= grantQ;
            state    <= GAP;
          end else if (holdCnt != HOLD_LAST_C) begin
            holdCnt <= holdCnt + 1'b1;
          end
        end
        default: begin
          grantQ <= '0;
          state  <= IDLE;
        end
      endcase
    end
  end

  logic              rwSel;
  logic [ADDR_W-1:0] addrSel;
  logic [DATA_W-1:0] wdataSel;

  always_comb begin
    rwSel    = 1'b0;
    addrSel  = '0;
    wdataSel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grantQ[i] && bus.req[i]) begin
        rwSel    = bus.req_rw[i];
        addrSel  = bus.req_addr[i*ADDR_W +: ADDR_W];
        wdataSel = bus.req_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  assign bus.grant      = grantQ;
  assign bus.preempted  = preemptQ;
  assign bus.dma_enable = |(grantQ & bus.req);
  assign bus.dma_rw     = rwSel;
  assign bus.dma_addr   = addrSel;
  assign bus.dma_wdata  = wdataSel;
  assign bus.busy       = (state == GRANT) || (state == GAP);

`ifdef DMA_ARB_STATS_EN
  logic [15:0] grantCnt [NUM_REQ];

  // Counts cycles that actually reached the DMA, wrapping naturally at 16 bits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REQ; i++) grantCnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (grantQ[i] && bus.req[i]) grantCnt[i] <= grantCnt[i] + 16'd1;
      end
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : gCount
    assign bus.grant_count[g*16 +: 16] = grantCnt[g];
  end
`endif
endmodule
